decode_operand: RTL
===================

Name: decode_operand

Overview:
- Decode/operand-fetch stage, directly upstream of the execute stage.
- Accepts a fetched instruction word and splits it into opecode, immf, cc and an extended immediate.
- Reads rd/rs from the register file (sub-module) and forwards in-flight results.
- Detects read-after-write hazards, inserts bubbles, and registers everything into the execute-facing pipeline register.

Parameters:
- LEN_INSN, 32, instruction word width
- LEN_OPECODE, 7, opecode field width
- LEN_IMMF, 1, immediate-flag width
- LEN_CC, 4, condition-code field width
- LEN_REG, 32, register data width
- LEN_REG_ADDR, 5, register index width (2^5 = 32 registers)
- LEN_IMM, 15, raw immediate width
- LEN_IMM_EX, 32, extended immediate width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- valid_i  in  1  insn_i valid from fetch
- insn_i  in  LEN_INSN  instruction word
- stall_o  out  1  hold request to fetch
- valid_o  out  1  output register holds a live instruction
- stall_i  in  1  hold request from execute
- opecode  out  LEN_OPECODE  to execute
- immf  out  LEN_IMMF  to execute
- cc  out  LEN_CC  to execute
- imm_ex  out  LEN_IMM_EX  to execute
- data_rd  out  LEN_REG  rd operand
- data_rs  out  LEN_REG  rs operand
- ex_valid  in  1  execute output register is live
- ex_we  in  1  that instruction writes rd
- ex_addr  in  LEN_REG_ADDR  its destination
- ex_data  in  LEN_REG  its final result (ALU or load)
- wb_we  in  1  writeback write enable
- wb_addr  in  LEN_REG_ADDR  writeback destination
- wb_data  in  LEN_REG  writeback data

Behaviour:
- Field layout:
  - [31:25] opecode, [24] immf, [23:20] cc, [19:15] rd, [14:10] rs, [14:0] imm.
  - imm and rs overlap; imm is meaningful only when immf=1.
- Immediate extension: imm_ex is imm zero-extended for opecode 001_0xxx (logic/setl/seth) and sign-extended from bit 14 otherwise.
- Writes rd: every opecode except cmp 000_0100, st 001_1001, j 001_1010, ja 001_1011, and 01x_xxxx (nop/hlt).
- Reads rd: opecodes 000_xxxx, 001_0xxx and st.
- Reads rs: immf=0 and opecode in 000_xxxx, 001_0xxx or 001_1xxx.
- Operand priority, per operand, highest first:
  1. ex_valid&ex_we&ex_addr==src → ex_data
  2. wb_we&wb_addr==src → wb_data
  3. register file read
- Register file is write-then-read: same-cycle wb write to a read address returns wb_data.
- Hazard: when valid_i, valid_o, the output-register instruction writes rd, and its rd equals a source the incoming instruction reads:
  - assert stall_o.
  - load a bubble (valid_o←0) on the next edge.
  - the dependent instruction is captured one cycle later via path 1.
- stall_o = (valid_o & stall_i) | hazard.
- Edge update, when ~(valid_o & stall_i):
  - hazard → valid_o←0, other outputs hold.
  - else valid_o←valid_i and all outputs capture decoded/forwarded values.
- When valid_o & stall_i: all outputs hold; a stalled bubble (valid_o=0) does not block.
- Latency: 1 cycle from accepted insn_i to outputs; 2 cycles on hazard.
- Reset (rst low, async):
  - valid_o=0.
  - opecode, immf, cc, imm_ex, data_rd, data_rs=0.
  - all registers in the register file=0.
  - Reset mid-stall discards the held instruction.
- Register 0 is an ordinary register (no hardwired zero).

Decomposition:
- Shared package defs_insn: the LEN_* constants, field bit positions, and opecode group constants (ADD group 000_0xxx, SHIFT 000_1xxx, LOGIC 001_0xxx, MEM/JUMP 001_1xxx, CMP, ST, J, JA).
- One sub-module reg_file: 2 async read ports, 1 sync write port with write-then-read bypass, async active-low reset.

Test Plan:
- Reset:
  - Stimulus: assert rst low mid-operation with valid_o=1.
  - Response: valid_o=0 and data_rd=0 immediately; after release, reading r3 returns 0.
- Immediate decode:
  - Stimulus: insn with opecode 000_0000, immf=1, imm=15'h7FFF.
  - Response: imm_ex=32'hFFFF_FFFF. The same imm with opecode 001_0101 gives 32'h0000_7FFF.
- Writeback bypass:
  - Stimulus: wb writes r5=32'h1234 in the same cycle as add r5,r5 is accepted.
  - Response: data_rd=data_rs=32'h1234 next cycle.
- RAW interlock:
  - Stimulus: add r2,r1 followed by sub r4,r2.
  - Response: stall_o=1 for one cycle and one valid_o=0 bubble. Sub is then captured with data_rs=ex_data (e.g. 32'hA5), which has priority over a stale wb_data for r2.
- Execute stall:
  - Stimulus: stall_i=1 for 3 cycles while valid_o=1.
  - Response: outputs unchanged and stall_o=1 throughout; the next instruction is captured on the first edge after stall_i falls.
- No false hazards:
  - Stimulus: cmp r1,r2 followed by add r1,r3.
  - Response: no stall, since cmp does not write.
  - Stimulus: immf=1 insn whose imm bits alias rs=r2 following a write to r2.
  - Response: no stall.

Source files
------------

// File: rtl/defs_insn.sv
// Instruction-format constants and opecode classification shared by the decode stage.
package defs_insn;

    localparam int LEN_INSN     = 32;
    localparam int LEN_OPECODE  = 7;
    localparam int LEN_IMMF     = 1;
    localparam int LEN_CC       = 4;
    localparam int LEN_REG      = 32;
    localparam int LEN_REG_ADDR = 5;
    localparam int LEN_IMM      = 15;
    localparam int LEN_IMM_EX   = 32;
    localparam int NUM_REGS     = 1 << LEN_REG_ADDR;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 25;
    localparam int IMMF_LO = 24;
    localparam int CC_HI   = 23;
    localparam int CC_LO   = 20;
    localparam int RD_HI   = 19;
    localparam int RD_LO   = 15;
    localparam int RS_HI   = 14;
    localparam int RS_LO   = 10;
    localparam int IMM_HI  = 14;
    localparam int IMM_LO  = 0;

    // Groups are matched on opecode[6:3].
    localparam logic [3:0] GRP_ADD   = 4'b0000;
    localparam logic [3:0] GRP_SHIFT = 4'b0001;
    localparam logic [3:0] GRP_LOGIC = 4'b0010;
    localparam logic [3:0] GRP_MEMJ  = 4'b0011;

    localparam logic [LEN_OPECODE-1:0] OPC_CMP = 7'b000_0100;
    localparam logic [LEN_OPECODE-1:0] OPC_ST  = 7'b001_1001;
    localparam logic [LEN_OPECODE-1:0] OPC_J   = 7'b001_1010;
    localparam logic [LEN_OPECODE-1:0] OPC_JA  = 7'b001_1011;

    function automatic logic writes_rd(input logic [LEN_OPECODE-1:0] op);
        return !(op == OPC_CMP || op == OPC_ST || op == OPC_J || op == OPC_JA ||
                 op[6:5] == 2'b01);
    endfunction

    function automatic logic reads_rd(input logic [LEN_OPECODE-1:0] op);
        return (op[6:3] == GRP_ADD) || (op[6:3] == GRP_SHIFT) ||
               (op[6:3] == GRP_LOGIC) || (op == OPC_ST);
    endfunction

    // ADD, SHIFT, LOGIC and MEM/JUMP groups together form 00x_xxxx.
    function automatic logic reads_rs(input logic [LEN_OPECODE-1:0] op, input logic immf);
        return !immf && (op[6:5] == 2'b00);
    endfunction

    function automatic logic [LEN_IMM_EX-1:0] extend_imm(input logic [LEN_OPECODE-1:0] op,
                                                         input logic [LEN_IMM-1:0] imm);
        if (op[6:3] == GRP_LOGIC)
            return {{(LEN_IMM_EX-LEN_IMM){1'b0}}, imm};
        return {{(LEN_IMM_EX-LEN_IMM){imm[LEN_IMM-1]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port; a
// same-cycle write to a read address is returned on that read port.
module reg_file
    import defs_insn::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LEN_REG_ADDR-1:0] raddr_a,
    output logic [LEN_REG-1:0]      rdata_a,
    input  logic [LEN_REG_ADDR-1:0] raddr_b,
    output logic [LEN_REG-1:0]      rdata_b,
    input  logic                    we,
    input  logic [LEN_REG_ADDR-1:0] waddr,
    input  logic [LEN_REG-1:0]      wdata
);

    logic [LEN_REG-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (we && waddr == raddr_a) ? wdata : regs[raddr_a];
    assign rdata_b = (we && waddr == raddr_b) ? wdata : regs[raddr_b];

endmodule

// File: rtl/decode_operand.sv
// Decode / operand-fetch stage: splits the instruction, fetches and forwards
// operands, interlocks on RAW against the instruction it is handing to execute.
module decode_operand
    import defs_insn::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [LEN_INSN-1:0]     insn_i,
    output logic                    stall_o,
    output logic                    valid_o,
    input  logic                    stall_i,
    output logic [LEN_OPECODE-1:0]  opecode,
    output logic [LEN_IMMF-1:0]     immf,
    output logic [LEN_CC-1:0]       cc,
    output logic [LEN_IMM_EX-1:0]   imm_ex,
    output logic [LEN_REG-1:0]      data_rd,
    output logic [LEN_REG-1:0]      data_rs,
    input  logic                    ex_valid,
    input  logic                    ex_we,
    input  logic [LEN_REG_ADDR-1:0] ex_addr,
    input  logic [LEN_REG-1:0]      ex_data,
    input  logic                    wb_we,
    input  logic [LEN_REG_ADDR-1:0] wb_addr,
    input  logic [LEN_REG-1:0]      wb_data
);

    logic [LEN_OPECODE-1:0]  op_d;
    logic [LEN_IMMF-1:0]     immf_d;
    logic [LEN_CC-1:0]       cc_d;
    logic [LEN_REG_ADDR-1:0] rd_d;
    logic [LEN_REG_ADDR-1:0] rs_d;
    logic [LEN_IMM-1:0]      imm_d;

    assign op_d   = insn_i[OPC_HI:OPC_LO];
    assign immf_d = insn_i[IMMF_LO +: LEN_IMMF];
    assign cc_d   = insn_i[CC_HI:CC_LO];
    assign rd_d   = insn_i[RD_HI:RD_LO];
    assign rs_d   = insn_i[RS_HI:RS_LO];
    assign imm_d  = insn_i[IMM_HI:IMM_LO];

    logic [LEN_REG-1:0] rf_rd;
    logic [LEN_REG-1:0] rf_rs;

    // The register file's write-through covers the writeback forwarding path.
    reg_file u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rd_d),
        .rdata_a (rf_rd),
        .raddr_b (rs_d),
        .rdata_b (rf_rs),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    logic ex_fwd_ok;
    logic [LEN_REG-1:0] fwd_rd;
    logic [LEN_REG-1:0] fwd_rs;

    assign ex_fwd_ok = ex_valid && ex_we;
    assign fwd_rd    = (ex_fwd_ok && ex_addr == rd_d) ? ex_data : rf_rd;
    assign fwd_rs    = (ex_fwd_ok && ex_addr == rs_d) ? ex_data : rf_rs;

    // Destination of the instruction held in the output register, kept for the interlock.
    logic [LEN_REG_ADDR-1:0] out_rd;
    logic                    out_wr;
    logic                    hold;
    logic                    hazard;

    assign hold   = valid_o && stall_i;
    assign hazard = valid_i && valid_o && out_wr &&
                    ((reads_rd(op_d) && out_rd == rd_d) ||
                     (reads_rs(op_d, immf_d[0]) && out_rd == rs_d));
    assign stall_o = hold || hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            opecode <= '0;
            immf    <= '0;
            cc      <= '0;
            imm_ex  <= '0;
            data_rd <= '0;
            data_rs <= '0;
            out_rd  <= '0;
            out_wr  <= 1'b0;
        end else if (!hold) begin
            if (hazard) begin
                valid_o <= 1'b0;
            end else begin
                valid_o <= valid_i;
                opecode <= op_d;
                immf    <= immf_d;
                cc      <= cc_d;
                imm_ex  <= extend_imm(op_d, imm_d);
                data_rd <= fwd_rd;
                data_rs <= fwd_rs;
                out_rd  <= rd_d;
                out_wr  <= writes_rd(op_d);
            end
        end
    end

endmodule
